// File: rtl/ms_pkg.sv
// Shared encodings and sizing helpers for the MEM response stage.
package ms_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5,
    LD_WU   = 3'd6,
    LD_D    = 3'd7
  } ld_op_e;

  localparam int EXCP_NUM_WD_DFLT = 16;

  // Cancel counter must hold 0..max_outstand inclusive.
  function automatic int cancel_cnt_width(input int max_outstand);
    return $clog2(max_outstand + 1);
  endfunction

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// Combinational load data alignment and sign/zero extension.
module mem_resp_stage_load_align
  import ms_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      addr_low,
  input  logic [2:0]      ld_op,
  output logic [XLEN-1:0] result
);

  logic        a2;
  logic [5:0]  b_sh;
  logic [5:0]  h_sh;
  logic [5:0]  w_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Bit 2 of the address only selects a lane on a 64-bit bus.
  assign a2     = (XLEN == 64) ? addr_low[2] : 1'b0;
  assign b_sh   = {a2, addr_low[1:0], 3'b000};
  assign h_sh   = {a2, addr_low[1], 4'b0000};
  assign w_sh   = {a2, 5'b00000};
  assign byte_v = 8'(data >> b_sh);
  assign half_v = 16'(data >> h_sh);
  assign word_v = 32'(data >> w_sh);

  always_comb begin
    result = data;
    case (ld_op_e'(ld_op))
      LD_B:    result = XLEN'($signed(byte_v));
      LD_BU:   result = XLEN'(byte_v);
      LD_H:    result = addr_low[0] ? '0 : XLEN'($signed(half_v));
      LD_HU:   result = addr_low[0] ? '0 : XLEN'(half_v);
      LD_W:    result = XLEN'($signed(word_v));
      LD_WU:   result = XLEN'(word_v);
      LD_D:    result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage for a request/response data memory: waits for data_ok, buffers
// returned data under WS backpressure, and drops responses of flushed requests.
module mem_resp_stage
  import ms_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int EXCP_NUM_WD  = EXCP_NUM_WD_DFLT,
  parameter int MAX_OUTSTAND = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es_to_ms_valid,
  output logic                   ms_allowin,
  input  logic [31:0]            es_pc,
  input  logic [XLEN-1:0]        es_result,
  input  logic [4:0]             es_dest,
  input  logic                   es_gr_we,
  input  logic [2:0]             es_ld_op,
  input  logic                   es_req_sent,
  input  logic [2:0]             es_addr_low,
  input  logic                   es_excp,
  input  logic [EXCP_NUM_WD-1:0] es_excp_num,
  input  logic                   es_req_inflight,
  input  logic                   data_ok,
  input  logic [XLEN-1:0]        rdata,
  input  logic                   flush,
  input  logic                   ws_allowin,
  output logic                   ms_to_ws_valid,
  output logic [31:0]            ms_pc,
  output logic [XLEN-1:0]        ms_final_result,
  output logic [4:0]             ms_dest,
  output logic                   ms_gr_we,
  output logic                   ms_excp,
  output logic [EXCP_NUM_WD-1:0] ms_excp_num,
  output logic                   ms_fwd_valid,
  output logic                   ms_fwd_pending,
  output logic [XLEN-1:0]        ms_fwd_data
);

  localparam int CW = cancel_cnt_width(MAX_OUTSTAND);

  // Handshake: a transfer EX->MS happens when es_to_ms_valid & ms_allowin,
  // MS->WS when ms_to_ws_valid & ws_allowin; valid never waits on ready.

  logic                   ms_valid_q, ms_valid_d;
  logic [31:0]            pc_q, pc_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic [4:0]             dest_q, dest_d;
  logic                   gr_we_q, gr_we_d;
  logic [2:0]             ld_op_q, ld_op_d;
  logic                   req_sent_q, req_sent_d;
  logic [2:0]             addr_low_q, addr_low_d;
  logic                   excp_q, excp_d;
  logic [EXCP_NUM_WD-1:0] excp_num_q, excp_num_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [XLEN-1:0]        buf_data_q, buf_data_d;
  logic [CW-1:0]          cancel_cnt_q, cancel_cnt_d;

  logic                   ms_wait;
  logic                   resp_hit;
  logic                   ready_go;
  logic                   cancel_dec;
  logic [1:0]             cancel_inc;
  logic [CW+1:0]          cancel_sum;
  logic [XLEN-1:0]        load_data;
  logic [XLEN-1:0]        aligned;

  assign ms_wait        = ms_valid_q & req_sent_q & ~excp_q;
  assign resp_hit       = data_ok & (cancel_cnt_q == '0);
  assign ready_go       = ~ms_wait | buf_valid_q | resp_hit;
  assign ms_allowin     = ~ms_valid_q | (ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ready_go & ~flush;

  assign load_data = buf_valid_q ? buf_data_q : rdata;

  mem_resp_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .data     (load_data),
    .addr_low (addr_low_q),
    .ld_op    (ld_op_q),
    .result   (aligned)
  );

  assign ms_final_result = (ld_op_q != LD_NONE) ? aligned : result_q;
  assign ms_pc           = pc_q;
  assign ms_dest         = dest_q;
  assign ms_gr_we        = gr_we_q;
  assign ms_excp         = excp_q;
  assign ms_excp_num     = excp_num_q;
  assign ms_fwd_valid    = ms_valid_q & gr_we_q;
  assign ms_fwd_pending  = ms_valid_q & (ld_op_q != LD_NONE) & ms_wait & ~buf_valid_q & ~resp_hit;
  assign ms_fwd_data     = ms_final_result;

  // On flush, every request still owed a response must be skipped later:
  // the one MS is waiting on (unless answered now) plus the one held in EX.
  assign cancel_inc = {1'b0, ms_wait & ~buf_valid_q & ~resp_hit} + {1'b0, es_req_inflight};
  assign cancel_dec = data_ok & (cancel_cnt_q != '0);
  assign cancel_sum = (CW + 2)'(cancel_cnt_q) + (flush ? (CW + 2)'(cancel_inc) : '0)
                    - (CW + 2)'(cancel_dec);

  always_comb begin
    ms_valid_d   = flush ? 1'b0 : (ms_allowin ? es_to_ms_valid : ms_valid_q);
    pc_d         = pc_q;
    result_d     = result_q;
    dest_d       = dest_q;
    gr_we_d      = gr_we_q;
    ld_op_d      = ld_op_q;
    req_sent_d   = req_sent_q;
    addr_low_d   = addr_low_q;
    excp_d       = excp_q;
    excp_num_d   = excp_num_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    cancel_cnt_d = cancel_cnt_q;

    if (es_to_ms_valid & ms_allowin) begin
      pc_d       = es_pc;
      result_d   = es_result;
      dest_d     = es_dest;
      gr_we_d    = es_gr_we;
      ld_op_d    = es_ld_op;
      req_sent_d = es_req_sent;
      addr_low_d = es_addr_low;
      excp_d     = es_excp;
      excp_num_d = es_excp_num;
    end

    if (flush | (ready_go & ws_allowin)) begin
      buf_valid_d = 1'b0;
    end else if (resp_hit & ms_wait & ~buf_valid_q & ~ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = rdata;
    end

    if (cancel_sum > (CW + 2)'(MAX_OUTSTAND)) begin
      cancel_cnt_d = CW'(MAX_OUTSTAND);
    end else begin
      cancel_cnt_d = CW'(cancel_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      pc_q         <= '0;
      result_q     <= '0;
      dest_q       <= '0;
      gr_we_q      <= 1'b0;
      ld_op_q      <= LD_NONE;
      req_sent_q   <= 1'b0;
      addr_low_q   <= '0;
      excp_q       <= 1'b0;
      excp_num_q   <= '0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      pc_q         <= pc_d;
      result_q     <= result_d;
      dest_q       <= dest_d;
      gr_we_q      <= gr_we_d;
      ld_op_q      <= ld_op_d;
      req_sent_q   <= req_sent_d;
      addr_low_q   <= addr_low_d;
      excp_q       <= excp_d;
      excp_num_q   <= excp_num_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  a_resp_in_order: assert property (@(posedge clk) disable iff (reset) resp_hit |-> ms_wait);
  a_cancel_bound:  assert property (@(posedge clk) disable iff (reset)
                                    cancel_sum <= (CW + 2)'(MAX_OUTSTAND));

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: load alignment, backpressure buffer,
// cancel counter and exception/reset behaviour with hand-computed values.
module tb_mem_resp_stage;

  localparam int XLEN = 32;
  localparam int ENW  = 16;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_B    = 3'd1;
  localparam logic [2:0] OP_BU   = 3'd2;
  localparam logic [2:0] OP_H    = 3'd3;
  localparam logic [2:0] OP_HU   = 3'd4;
  localparam logic [2:0] OP_W    = 3'd5;

  logic            clk;
  logic            reset;
  logic            es_to_ms_valid;
  logic            ms_allowin;
  logic [31:0]     es_pc;
  logic [XLEN-1:0] es_result;
  logic [4:0]      es_dest;
  logic            es_gr_we;
  logic [2:0]      es_ld_op;
  logic            es_req_sent;
  logic [2:0]      es_addr_low;
  logic            es_excp;
  logic [ENW-1:0]  es_excp_num;
  logic            es_req_inflight;
  logic            data_ok;
  logic [XLEN-1:0] rdata;
  logic            flush;
  logic            ws_allowin;
  logic            ms_to_ws_valid;
  logic [31:0]     ms_pc;
  logic [XLEN-1:0] ms_final_result;
  logic [4:0]      ms_dest;
  logic            ms_gr_we;
  logic            ms_excp;
  logic [ENW-1:0]  ms_excp_num;
  logic            ms_fwd_valid;
  logic            ms_fwd_pending;
  logic [XLEN-1:0] ms_fwd_data;

  int n_vec;
  int n_err;

  mem_resp_stage #(.XLEN(XLEN), .EXCP_NUM_WD(ENW), .MAX_OUTSTAND(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_result       (es_result),
    .es_dest         (es_dest),
    .es_gr_we        (es_gr_we),
    .es_ld_op        (es_ld_op),
    .es_req_sent     (es_req_sent),
    .es_addr_low     (es_addr_low),
    .es_excp         (es_excp),
    .es_excp_num     (es_excp_num),
    .es_req_inflight (es_req_inflight),
    .data_ok         (data_ok),
    .rdata           (rdata),
    .flush           (flush),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_final_result (ms_final_result),
    .ms_dest         (ms_dest),
    .ms_gr_we        (ms_gr_we),
    .ms_excp         (ms_excp),
    .ms_excp_num     (ms_excp_num),
    .ms_fwd_valid    (ms_fwd_valid),
    .ms_fwd_pending  (ms_fwd_pending),
    .ms_fwd_data     (ms_fwd_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [2:0] op,
                       input logic [2:0] alow, input logic rs, input logic ex,
                       input logic [ENW-1:0] exnum);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_result      = res;
    es_dest        = 5'd4;
    es_gr_we       = (op != OP_NONE) || !rs;
    es_ld_op       = op;
    es_req_sent    = rs;
    es_addr_low    = alow;
    es_excp        = ex;
    es_excp_num    = exnum;
    step();
    es_to_ms_valid = 1'b0;
  endtask

  // Issue a load, answer it on the following cycle, check the result.
  task automatic load_vec(input string tag, input logic [2:0] op, input logic [2:0] alow,
                          input logic [31:0] data, input logic [31:0] exp);
    issue(32'h1c00_0100, 32'h0000_1000 | 32'(alow), op, alow, 1'b1, 1'b0, '0);
    data_ok = 1'b1;
    rdata   = data;
    #1;
    chk({tag, "_valid"}, 64'(ms_to_ws_valid), 64'd1);
    chk(tag, 64'(ms_final_result), 64'(exp));
    step();
    data_ok = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    es_to_ms_valid = 1'b0; es_pc = '0; es_result = '0; es_dest = '0; es_gr_we = 1'b0;
    es_ld_op = OP_NONE; es_req_sent = 1'b0; es_addr_low = '0; es_excp = 1'b0;
    es_excp_num = '0; es_req_inflight = 1'b0; data_ok = 1'b0; rdata = '0;
    flush = 1'b0; ws_allowin = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_to_ws", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_pc", 64'(ms_pc), 64'd0);
    chk("rst_result", 64'(ms_final_result), 64'd0);
    chk("rst_fwd", 64'({ms_fwd_valid, ms_fwd_pending}), 64'd0);
    chk("rst_cancel", 64'(dut.cancel_cnt_q), 64'd0);

    // 1: ld.w answered two cycles after issue
    issue(32'h1c00_0000, 32'h0000_1000, OP_W, 3'd0, 1'b1, 1'b0, '0);
    #1;
    chk("t1_wait_to_ws", 64'(ms_to_ws_valid), 64'd0);
    chk("t1_wait_allowin", 64'(ms_allowin), 64'd0);
    chk("t1_pending", 64'(ms_fwd_pending), 64'd1);
    step();
    data_ok = 1'b1;
    rdata   = 32'h8000_00F0;
    #1;
    chk("t1_to_ws", 64'(ms_to_ws_valid), 64'd1);
    chk("t1_result", 64'(ms_final_result), 64'h8000_00F0);
    chk("t1_pc", 64'(ms_pc), 64'h1c00_0000);
    chk("t1_no_pending", 64'(ms_fwd_pending), 64'd0);
    step();
    data_ok = 1'b0;
    #1;
    chk("t1_gone", 64'(ms_to_ws_valid), 64'd0);

    // 2: alignment and extension
    load_vec("t2_ldb", OP_B, 3'd3, 32'h8012_3456, 32'hFFFF_FF80);
    load_vec("t2_ldbu", OP_BU, 3'd3, 32'h8012_3456, 32'h0000_0080);
    load_vec("t2_ldh", OP_H, 3'd2, 32'h8001_1234, 32'hFFFF_8001);
    load_vec("t2_ldhu", OP_HU, 3'd0, 32'h1234_F00D, 32'h0000_F00D);
    load_vec("t2_ldb1", OP_B, 3'd1, 32'h0000_7F00, 32'h0000_007F);
    load_vec("t2_ldh_mis", OP_H, 3'd1, 32'hFFFF_FFFF, 32'h0000_0000);

    // ALU op goes straight through; a store waits and reports es_result
    issue(32'h1c00_0200, 32'hDEAD_BEEF, OP_NONE, 3'd0, 1'b0, 1'b0, '0);
    #1;
    chk("t2_alu_to_ws", 64'(ms_to_ws_valid), 64'd1);
    chk("t2_alu_fwd", 64'({ms_fwd_valid, ms_fwd_pending}), 64'b10);
    chk("t2_alu_data", 64'(ms_fwd_data), 64'hDEAD_BEEF);
    step();
    issue(32'h1c00_0204, 32'h0000_2000, OP_NONE, 3'd0, 1'b1, 1'b0, '0);
    #1;
    chk("t2_st_wait", 64'(ms_to_ws_valid), 64'd0);
    data_ok = 1'b1;
    rdata   = 32'h5555_5555;
    #1;
    chk("t2_st_done", 64'(ms_to_ws_valid), 64'd1);
    chk("t2_st_result", 64'(ms_final_result), 64'h0000_2000);
    step();
    data_ok = 1'b0;

    // 3: response buffered under WS backpressure
    issue(32'h1c00_0300, 32'h0000_3000, OP_W, 3'd0, 1'b1, 1'b0, '0);
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata      = 32'h1122_3344;
    #1;
    chk("t3_hit_valid", 64'(ms_to_ws_valid), 64'd1);
    step();
    data_ok = 1'b0;
    rdata   = 32'hFFFF_FFFF;
    #1;
    chk("t3_buf_valid", 64'(dut.buf_valid_q), 64'd1);
    chk("t3_hold1", 64'(ms_final_result), 64'h1122_3344);
    chk("t3_hold_allowin", 64'(ms_allowin), 64'd0);
    step();
    rdata = 32'h0;
    #1;
    chk("t3_hold2", 64'(ms_final_result), 64'h1122_3344);
    step();
    ws_allowin = 1'b1;
    #1;
    chk("t3_send_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t3_send", 64'(ms_final_result), 64'h1122_3344);
    chk("t3_send_allowin", 64'(ms_allowin), 64'd1);
    step();
    chk("t3_buf_clear", 64'(dut.buf_valid_q), 64'd0);
    chk("t3_gone", 64'(ms_to_ws_valid), 64'd0);

    // 4: flush while waiting with a request in EX -> two responses dropped
    issue(32'h1c00_0400, 32'h0000_4000, OP_W, 3'd0, 1'b1, 1'b0, '0);
    flush           = 1'b1;
    es_req_inflight = 1'b1;
    #1;
    chk("t4_flush_to_ws", 64'(ms_to_ws_valid), 64'd0);
    step();
    flush           = 1'b0;
    es_req_inflight = 1'b0;
    #1;
    chk("t4_cancel2", 64'(dut.cancel_cnt_q), 64'd2);
    chk("t4_empty", 64'(ms_allowin), 64'd1);
    data_ok = 1'b1;
    rdata   = 32'hAAAA_0001;
    issue(32'h1c00_0410, 32'h0000_4100, OP_W, 3'd0, 1'b1, 1'b0, '0);
    rdata = 32'hBBBB_0002;
    #1;
    chk("t4_cancel1", 64'(dut.cancel_cnt_q), 64'd1);
    chk("t4_drop2", 64'(ms_to_ws_valid), 64'd0);
    chk("t4_drop2_pend", 64'(ms_fwd_pending), 64'd1);
    step();
    rdata = 32'h1234_5678;
    #1;
    chk("t4_cancel0", 64'(dut.cancel_cnt_q), 64'd0);
    chk("t4_third_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t4_third", 64'(ms_final_result), 64'h1234_5678);
    step();
    data_ok = 1'b0;

    // 5: flush coinciding with a dropped response nets to no change
    issue(32'h1c00_0500, 32'h0000_5000, OP_W, 3'd0, 1'b1, 1'b0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t5_cancel1", 64'(dut.cancel_cnt_q), 64'd1);
    flush           = 1'b1;
    es_req_inflight = 1'b1;
    data_ok         = 1'b1;
    step();
    flush           = 1'b0;
    es_req_inflight = 1'b0;
    #1;
    chk("t5_net", 64'(dut.cancel_cnt_q), 64'd1);
    step();
    data_ok = 1'b0;
    #1;
    chk("t5_drain", 64'(dut.cancel_cnt_q), 64'd0);

    // 6: excepting instruction never waits
    issue(32'h1c00_0600, 32'h0000_6001, OP_W, 3'd1, 1'b1, 1'b1, 16'h0009);
    #1;
    chk("t6_excp_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t6_excp", 64'({ms_excp, ms_excp_num}), 64'h1_0009);
    chk("t6_excp_pend", 64'(ms_fwd_pending), 64'd0);
    step();

    // Reset mid-wait; a late response during reset leaves no trace
    issue(32'h1c00_0700, 32'h0000_7000, OP_W, 3'd0, 1'b1, 1'b0, '0);
    #1;
    chk("t6_waiting", 64'(ms_fwd_pending), 64'd1);
    reset = 1'b1;
    step();
    data_ok = 1'b1;
    rdata   = 32'hCAFE_F00D;
    step();
    reset   = 1'b0;
    data_ok = 1'b0;
    #1;
    chk("t6_rst_allowin", 64'(ms_allowin), 64'd1);
    chk("t6_rst_to_ws", 64'(ms_to_ws_valid), 64'd0);
    chk("t6_rst_pc", 64'(ms_pc), 64'd0);
    chk("t6_rst_result", 64'(ms_final_result), 64'd0);
    chk("t6_rst_state", 64'({dut.buf_valid_q, dut.cancel_cnt_q}), 64'd0);
    step();
    chk("t6_post_idle", 64'(ms_to_ws_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
